// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants and the register-file FSM state type.
// Optional feature macro used by regfile_wb: REGFILE_WB_BYPASS_EN.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;
    localparam int         NREG  = 15;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;
endpackage

// File: rtl/wb_dst.sv
// wb_dst: combinational writeback destination decode (dstE/dstM) from icode.
module wb_dst
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);
    // E port: conditional moves only write when the condition holds
    always_comb begin
        dstE = RNONE;
        case (icode)
            IRRMOVQ:                     dstE = cnd ? rB : RNONE;
            IIRMOVQ, IOPQ:               dstE = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  dstE = RSP;
            default:                     dstE = RNONE;
        endcase
    end

    // M port: loads from memory
    always_comb begin
        dstM = RNONE;
        case (icode)
            IMRMOVQ, IPOPQ: dstM = rA;
            default:        dstM = RNONE;
        endcase
    end
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: 15x64 Y86-64 register file with writeback handshake and a
// clearing sweep after reset / clr. Define REGFILE_WB_BYPASS_EN to forward
// the current-cycle writeback data onto the read ports.
module regfile_wb
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic        clr,
    output logic [63:0] reg_memrA,
    output logic [63:0] reg_memrB,
    output logic [63:0] reg_memr4,
    output logic [31:0] wb_count
);
    logic [63:0] r_regs [NREG];
    state_t      r_state;
    logic [3:0]  r_idx;
    logic [31:0] r_cnt;

    logic [3:0]  w_dstE, w_dstM;
    logic        w_xfer;
    logic [3:0]  w_raddr [3];
    logic [63:0] w_rdata [3];

    wb_dst u_dst (
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .dstE  (w_dstE),
        .dstM  (w_dstM)
    );

    assign wb_ready = (r_state == READY) && !clr;
    assign w_xfer   = wb_valid && wb_ready;
    assign wb_count = r_cnt;

    // Control: sweep index walk, clr restart, accepted-transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_xfer)
                r_cnt <= r_cnt + 32'd1;
            if (clr) begin
                r_state <= SWEEP;
                r_idx   <= '0;
            end else if (r_state == SWEEP) begin
                if (r_idx == 4'(NREG - 1)) begin
                    r_state <= READY;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    // Array: zero one entry per sweep cycle, else commit the writeback.
    // M wins when both ports target the same register (popq %rsp).
    always_ff @(posedge clk) begin
        if (r_state == SWEEP) begin
            r_regs[r_idx] <= '0;
        end else if (w_xfer) begin
            if (w_dstE != RNONE && w_dstE != w_dstM)
                r_regs[w_dstE] <= valE;
            if (w_dstM != RNONE)
                r_regs[w_dstM] <= valM;
        end
    end

    assign w_raddr[0] = rA;
    assign w_raddr[1] = rB;
    assign w_raddr[2] = RSP;

    // Combinational read ports; forced to zero while sweeping or in reset
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rdata[p] = '0;
            if (r_state == READY && w_raddr[p] != RNONE)
                w_rdata[p] = r_regs[w_raddr[p]];
`ifdef REGFILE_WB_BYPASS_EN
            if (w_xfer) begin
                if (w_dstM != RNONE && w_raddr[p] == w_dstM)
                    w_rdata[p] = valM;
                else if (w_dstE != RNONE && w_raddr[p] == w_dstE)
                    w_rdata[p] = valE;
            end
`endif
        end
    end

    assign reg_memrA = w_rdata[0];
    assign reg_memrB = w_rdata[1];
    assign reg_memr4 = w_rdata[2];
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed + randomized checks of regfile_wb against an
// array-based reference model of the Y86-64 writeback rules.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA, rB;
    logic [63:0] valE, valM;
    logic        wb_valid;
    logic        wb_ready;
    logic        clr;
    logic [63:0] reg_memrA, reg_memrB, reg_memr4;
    logic [31:0] wb_count;

    int checks = 0;
    int failures = 0;

    logic [63:0] m_regs [15];
    logic [31:0] m_cnt;

    regfile_wb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .icode     (icode),
        .cnd       (cnd),
        .rA        (rA),
        .rB        (rB),
        .valE      (valE),
        .valM      (valM),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .clr       (clr),
        .reg_memrA (reg_memrA),
        .reg_memrB (reg_memrB),
        .reg_memr4 (reg_memr4),
        .wb_count  (wb_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Destinations straight from the Y86-64 writeback table
    task automatic mdst(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                        input logic [3:0] rb, output logic [3:0] de, output logic [3:0] dm);
        de = 4'hF;
        dm = 4'hF;
        if (ic == 4'h2 && c) de = rb;
        if (ic == 4'h3 || ic == 4'h6) de = rb;
        if (ic >= 4'h8 && ic <= 4'hB) de = 4'h4;
        if (ic == 4'h5 || ic == 4'hB) dm = ra;
    endtask

    function automatic logic [63:0] mref(input logic [3:0] a);
        return (a == 4'hF) ? 64'd0 : m_regs[a];
    endfunction

    task automatic mclear;
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
    endtask

    // One accepted writeback; model commits E then M so M wins on collision
    task automatic drive_wb(input logic [3:0] ic, input logic c, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm);
        logic [3:0] de, dm;
        icode = ic; cnd = c; rA = ra; rB = rb; valE = ve; valM = vm; wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        mdst(ic, c, ra, rb, de, dm);
        if (de != 4'hF) m_regs[de] = ve;
        if (dm != 4'hF) m_regs[dm] = vm;
        m_cnt++;
    endtask

    task automatic chk_reads(input string tag, input logic [3:0] ra, input logic [3:0] rb);
        wb_valid = 1'b0;
        rA = ra; rB = rb;
        #1;
        chk({tag, ".rA"}, reg_memrA, mref(ra));
        chk({tag, ".rB"}, reg_memrB, mref(rb));
        chk({tag, ".r4"}, reg_memr4, m_regs[4]);
        chk({tag, ".cnt"}, 64'(wb_count), 64'(m_cnt));
    endtask

    task automatic wait_sweep(input string tag);
        for (int i = 0; i < 15; i++) begin
            chk(tag, 64'(wb_ready), 64'd0);
            tick();
        end
        chk({tag, ".ready"}, 64'(wb_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] exp_byp;
        logic [31:0] c0;
        rst_n = 1'b0; icode = '0; cnd = 1'b0; rA = '0; rB = '0;
        valE = '0; valM = '0; wb_valid = 1'b0; clr = 1'b0;
        m_cnt = '0;
        mclear();

        // In reset
        #3;
        chk("rst.ready", 64'(wb_ready), 64'd0);
        chk("rst.rA", reg_memrA, 64'd0);
        chk("rst.r4", reg_memr4, 64'd0);
        chk("rst.cnt", 64'(wb_count), 64'd0);

        // Post-reset sweep: 15 cycles low, ready on the 16th
        #14 rst_n = 1'b1;
        wait_sweep("sweep0");
        for (int i = 0; i < 15; i++) chk_reads("zero", 4'(i), 4'(14 - i));

        // irmovq to %rdx
        drive_wb(4'h3, 1'b0, 4'hF, 4'h2, 64'h1234, 64'h0);
        chk_reads("irmovq", 4'h0, 4'h2);

        // cmov not taken, then taken
        drive_wb(4'h2, 1'b0, 4'h1, 4'h5, 64'd7, 64'h0);
        chk_reads("cmov0", 4'h1, 4'h5);
        chk("cmov0.r5", reg_memrB, 64'd0);
        drive_wb(4'h2, 1'b1, 4'h1, 4'h5, 64'd7, 64'h0);
        chk_reads("cmov1", 4'h1, 4'h5);
        chk("cmov1.r5", reg_memrB, 64'd7);

        // popq %rsp: valM wins
        drive_wb(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'h55);
        chk_reads("poprsp", 4'h4, 4'hF);
        chk("poprsp.r4", reg_memr4, 64'h55);

        // Same-cycle read of a register being written by OPq
        icode = 4'h6; cnd = 1'b0; rA = 4'h3; rB = 4'h3; valE = 64'd9; valM = 64'h0;
        wb_valid = 1'b1;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        exp_byp = 64'd9;
`else
        exp_byp = m_regs[3];
`endif
        chk("bypass.rA", reg_memrA, exp_byp);
        drive_wb(4'h6, 1'b0, 4'h3, 4'h3, 64'd9, 64'h0);
        chk_reads("opq", 4'h3, 4'h3);

        // Randomized writebacks and reads
        for (int n = 0; n < 60; n++) begin
            logic [3:0] ic, ra, rb;
            logic [63:0] ve, vm;
            ic = 4'($urandom_range(0, 11));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            ve = {$urandom, $urandom};
            vm = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                drive_wb(ic, 1'($urandom_range(0, 1)), ra, rb, ve, vm);
            else
                tick();
            chk_reads("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // clr with a concurrent writeback: dropped, sweep, count kept
        c0 = m_cnt;
        icode = 4'h3; rB = 4'h7; valE = 64'hFF; wb_valid = 1'b1; clr = 1'b1;
        #1;
        chk("clr.ready", 64'(wb_ready), 64'd0);
        tick();
        clr = 1'b0; wb_valid = 1'b0;
        mclear();
        for (int i = 0; i < 5; i++) tick();
        chk("clr.mid", 64'(wb_ready), 64'd0);
        // clr during sweep restarts it from index 0
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_sweep("sweep1");
        for (int i = 0; i < 15; i++) chk_reads("clr.zero", 4'(i), 4'h7);
        chk("clr.cnt", 64'(wb_count), 64'(c0));

        // Reset in the middle of a sweep restarts it
        drive_wb(4'h3, 1'b0, 4'hF, 4'h9, 64'hABC, 64'h0);
        chk_reads("prerst", 4'h9, 4'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #2;
        m_cnt = '0;
        mclear();
        chk("rst2.cnt", 64'(wb_count), 64'd0);
        chk("rst2.ready", 64'(wb_ready), 64'd0);
        #2 rst_n = 1'b1;
        wait_sweep("sweep2");
        chk_reads("rst2", 4'h9, 4'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
